dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single data-RAM port between the pipeline memory-access stage (port M) and an external debug/program-loader master (port D). Grants at most one access per cycle, drives the RAM control/address/data lines, and routes read data back to the requester that issued the read. Raises a stall to the pipeline whenever an M request is refused. A starvation counter and a D-side burst lock keep D from being locked out. The block sits between the memory-access stage and the `ram` instance.

## Interface
- STARVE_MAX, 4: consecutive refused D-request cycles before D is forced to win (1..15).
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  synchronous, active-high reset
- m_req_i  in  1  M access request (load or store)
- m_we_i  in  1  M write (1 = store, 0 = load)
- m_funct_i  in  10  M funct (byte/half/word, sign), passed to RAM
- m_addr_i  in  32  M byte address
- m_wdata_i  in  32  M store data
- m_gnt_o  out  1  M request accepted this cycle
- m_stall_o  out  1  m_req_i & ~m_gnt_o
- m_rvalid_o  out  1  M read data valid (one cycle after M read grant)
- m_rdata_o  out  32  M read data
- d_req_i, d_we_i, d_funct_i[9:0], d_addr_i[31:0], d_wdata_i[31:0]  in  same meanings for D
- d_lock_i  in  1  D asks to keep ownership across back-to-back requests
- d_gnt_o, d_rvalid_o  out  1  same meanings for D
- d_rdata_o  out  32  D read data
- ram_r_en_o, ram_w_en_o  out  1  RAM read / write enables
- ram_funct_o  out  10  RAM funct
- ram_addr_o, ram_wdata_o  out  32  RAM address / write data
- ram_rdata_i  in  32  RAM read data, valid one cycle after ram_r_en_o

## Operation
- Grants are combinational from the requests and the registered state. A request is consumed in the cycle its grant is high. A requester holds req and its payload stable until granted.
- FSM states: ARB (reset state), D_LOCK.
- ARB grant rule, in priority order:
  - D wins if d_req_i and starve_cnt == STARVE_MAX.
  - Otherwise M wins if m_req_i.
  - Otherwise D wins if d_req_i.
- ARB -> D_LOCK when D is granted with d_lock_i = 1.
- D_LOCK: only D can be granted, and it is granted whenever d_req_i = 1. M is refused and stalled.
- D_LOCK -> ARB on the first cycle with d_lock_i = 0, whether or not D requests. In that cycle ARB rules apply combinationally, so M can be granted the same cycle.
- starve_cnt (4 bits):
  - Resets to 0.
  - Increments, saturating at STARVE_MAX, each cycle d_req_i = 1 and d_gnt_o = 0.
  - Clears to 0 on any d_gnt_o, or when d_req_i = 0.
- RAM drive on a grant:
  - ram_r_en_o = ~we, ram_w_en_o = we.
  - addr, funct and wdata come from the winner; wdata is 0 for reads.
- With no grant: enables are 0 and addr/funct/wdata are 0.
- Read return: registered rd_owner (NONE/M/D) is set on the cycle of a read grant.
  - On the next cycle the owner's rvalid = 1 and its rdata = ram_rdata_i.
  - The non-owner's rdata = 0.
- Writes produce no rvalid.
- Back-to-back reads to alternating owners are legal; each returns to its own issuer.

## Timing
- Reset (rst_i high at an edge): state = ARB, starve_cnt = 0, rd_owner = NONE. Therefore rvalid = 0 and rdata = 0 on both ports the cycle after.
- While rst_i is high, all grants and RAM enables are 0. M stall follows m_req_i.
- Reset mid-read: a read granted in the cycle reset is asserted returns no rvalid.
- Read latency: grant in cycle N gives rvalid in cycle N+1. Throughput is one access per cycle.
- Write latency: committed by RAM at the edge ending the grant cycle.
- Grant and stall are combinational, with no registered delay. m_gnt_o and d_gnt_o are never both 1.
- Simultaneous M and D requests with starve_cnt < STARVE_MAX: M is granted, D is refused, and starve_cnt increments.
- Simultaneous requests with starve_cnt == STARVE_MAX: D is granted, M stalls one cycle, and starve_cnt returns to 0.
- D_LOCK with d_req_i = 0: no grant, and M keeps stalling until d_lock_i falls.

## Test plan
- Single M load: m_req=1, we=0, addr=0x100 in cycle 0. Expect m_gnt=1, ram_r_en=1, ram_addr=0x100 in cycle 0. Expect m_rvalid=1, m_rdata=ram_rdata in cycle 1, with d_rvalid=0.
- Continuous contention with STARVE_MAX=4: m_req and d_req both held high. M is granted cycles 0-3 and D in cycle 4. Then M again for 4 cycles; m_stall=1 only in cycle 4.
- Lock burst: D requests with d_lock=1 for 3 cycles while m_req=1. Expect d_gnt in cycles 0-2 and m_stall=1. d_lock=0 in cycle 3 gives m_gnt=1 in cycle 3.
- Interleaved reads: M read in cycle 0, D read in cycle 1 (M idle). Expect m_rvalid in cycle 1 and d_rvalid in cycle 2, each carrying its own RAM data.
- Store: M store addr=0x20, wdata=0xDEADBEEF. Expect ram_w_en=1 and ram_wdata=0xDEADBEEF, with no rvalid. A following load from 0x20 returns 0xDEADBEEF.
- Reset mid-operation: a D read is granted while rst_i=1 is applied with starve_cnt=3. The next cycle shows d_rvalid=0 and state ARB, and M wins the next contention.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-RAM port arbiter between the pipeline memory stage (M) and a debug/loader master (D).
// Single-cycle grants, starvation protection and D burst lock; read data is steered back to its issuer.
module dmem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m_req_i,
  input  logic        m_we_i,
  input  logic [9:0]  m_funct_i,
  input  logic [31:0] m_addr_i,
  input  logic [31:0] m_wdata_i,
  output logic        m_gnt_o,
  output logic        m_stall_o,
  output logic        m_rvalid_o,
  output logic [31:0] m_rdata_o,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic [9:0]  d_funct_i,
  input  logic [31:0] d_addr_i,
  input  logic [31:0] d_wdata_i,
  input  logic        d_lock_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        ram_r_en_o,
  output logic        ram_w_en_o,
  output logic [9:0]  ram_funct_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_D_LOCK = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M    = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_r;
  owner_t      rd_owner_r;
  logic [3:0]  starve_cnt_r;

  logic        in_lock_s;
  logic        d_forced_s;
  logic        m_gnt_s;
  logic        d_gnt_s;
  logic        ram_r_en_s;
  logic        ram_w_en_s;
  logic [9:0]  ram_funct_s;
  logic [31:0] ram_addr_s;
  logic [31:0] ram_wdata_s;

  // Grant selection: lock hold first, then starvation override, then M priority.
  always_comb begin
    m_gnt_s    = 1'b0;
    d_gnt_s    = 1'b0;
    in_lock_s  = (state_r == ST_D_LOCK) && d_lock_i;
    d_forced_s = d_req_i && (starve_cnt_r == STARVE_LIM);
    if (rst_i) begin
      m_gnt_s = 1'b0;
      d_gnt_s = 1'b0;
    end else if (in_lock_s) begin
      d_gnt_s = d_req_i;
    end else if (d_forced_s) begin
      d_gnt_s = 1'b1;
    end else if (m_req_i) begin
      m_gnt_s = 1'b1;
    end else begin
      d_gnt_s = d_req_i;
    end
  end

  // RAM port mux from the winner; everything quiet when nobody is granted.
  always_comb begin
    ram_r_en_s  = 1'b0;
    ram_w_en_s  = 1'b0;
    ram_funct_s = 10'h000;
    ram_addr_s  = 32'h0000_0000;
    ram_wdata_s = 32'h0000_0000;
    if (m_gnt_s) begin
      ram_r_en_s  = ~m_we_i;
      ram_w_en_s  = m_we_i;
      ram_funct_s = m_funct_i;
      ram_addr_s  = m_addr_i;
      ram_wdata_s = m_we_i ? m_wdata_i : 32'h0000_0000;
    end else if (d_gnt_s) begin
      ram_r_en_s  = ~d_we_i;
      ram_w_en_s  = d_we_i;
      ram_funct_s = d_funct_i;
      ram_addr_s  = d_addr_i;
      ram_wdata_s = d_we_i ? d_wdata_i : 32'h0000_0000;
    end else begin
      ram_r_en_s  = 1'b0;
      ram_w_en_s  = 1'b0;
    end
  end

  // Arbiter FSM, starvation counter and read-return owner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_ARB;
      starve_cnt_r <= 4'd0;
      rd_owner_r   <= OWN_NONE;
    end else begin
      // Stay locked while D keeps d_lock_i high; any lock-granted D access enters the lock.
      if (in_lock_s || (d_gnt_s && d_lock_i)) begin
        state_r <= ST_D_LOCK;
      end else begin
        state_r <= ST_ARB;
      end

      if (d_gnt_s || !d_req_i) begin
        starve_cnt_r <= 4'd0;
      end else if (starve_cnt_r != STARVE_LIM) begin
        starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end

      if (m_gnt_s && !m_we_i) begin
        rd_owner_r <= OWN_M;
      end else if (d_gnt_s && !d_we_i) begin
        rd_owner_r <= OWN_D;
      end else begin
        rd_owner_r <= OWN_NONE;
      end
    end
  end

  assign m_gnt_o     = m_gnt_s;
  assign d_gnt_o     = d_gnt_s;
  assign m_stall_o   = m_req_i & ~m_gnt_s;

  assign m_rvalid_o  = (rd_owner_r == OWN_M);
  assign d_rvalid_o  = (rd_owner_r == OWN_D);
  assign m_rdata_o   = (rd_owner_r == OWN_M) ? ram_rdata_i : 32'h0000_0000;
  assign d_rdata_o   = (rd_owner_r == OWN_D) ? ram_rdata_i : 32'h0000_0000;

  assign ram_r_en_o  = ram_r_en_s;
  assign ram_w_en_o  = ram_w_en_s;
  assign ram_funct_o = ram_funct_s;
  assign ram_addr_o  = ram_addr_s;
  assign ram_wdata_o = ram_wdata_s;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Table-driven bench for dmem_arbiter with a small RAM model and a read-return scoreboard.
module tb_dmem_arbiter;

  localparam logic [9:0] M_FUNCT = 10'h002;
  localparam logic [9:0] D_FUNCT = 10'h00A;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m_req_i, m_we_i;
  logic [9:0]  m_funct_i;
  logic [31:0] m_addr_i, m_wdata_i;
  logic        m_gnt_o, m_stall_o, m_rvalid_o;
  logic [31:0] m_rdata_o;
  logic        d_req_i, d_we_i, d_lock_i;
  logic [9:0]  d_funct_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic        d_gnt_o, d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        ram_r_en_o, ram_w_en_o;
  logic [9:0]  ram_funct_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          rst;
    bit          m_req;
    bit          m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          d_req;
    bit          d_we;
    bit          d_lock;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    bit          exp_m_gnt;
    bit          exp_d_gnt;
  } vec_t;

  typedef struct {
    bit          m_v;
    bit          d_v;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] shadow[256];
  logic [31:0] ram_mem[256];

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m_req_i(m_req_i), .m_we_i(m_we_i), .m_funct_i(m_funct_i),
    .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_stall_o(m_stall_o),
    .m_rvalid_o(m_rvalid_o), .m_rdata_o(m_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_funct_i(d_funct_i),
    .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i), .d_lock_i(d_lock_i),
    .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .ram_r_en_o(ram_r_en_o), .ram_w_en_o(ram_w_en_o), .ram_funct_o(ram_funct_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] pat(input int idx);
    return 32'hC0DE_0000 ^ (idx * 32'h0001_0101);
  endfunction

  // Word-wide RAM model: one-cycle read latency, contents preset while reset is held.
  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= pat(i);
    end else begin
      if (ram_w_en_o) ram_mem[ram_addr_o[9:2]] <= ram_wdata_o;
      if (ram_r_en_o) ram_rdata_i <= ram_mem[ram_addr_o[9:2]];
    end
  end

  function automatic vec_t mk(bit rst, bit mreq, bit mwe, logic [31:0] maddr, logic [31:0] mwd,
                              bit dreq, bit dwe, bit dlock, logic [31:0] daddr, logic [31:0] dwd,
                              bit em, bit ed);
    vec_t v;
    v.rst = rst; v.m_req = mreq; v.m_we = mwe; v.m_addr = maddr; v.m_wdata = mwd;
    v.d_req = dreq; v.d_we = dwe; v.d_lock = dlock; v.d_addr = daddr; v.d_wdata = dwd;
    v.exp_m_gnt = em; v.exp_d_gnt = ed;
    return v;
  endfunction

  task automatic chk(input string tag, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %h want %h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle, check return data of the previous cycle and this cycle's grant/RAM drive.
  task automatic step(input vec_t v, input string tag);
    exp_t        e;
    exp_t        n;
    bit          we;
    logic [31:0] addr, wd;
    logic [9:0]  fn;
    rst_i = v.rst;
    m_req_i = v.m_req; m_we_i = v.m_we; m_addr_i = v.m_addr; m_wdata_i = v.m_wdata; m_funct_i = M_FUNCT;
    d_req_i = v.d_req; d_we_i = v.d_we; d_lock_i = v.d_lock; d_addr_i = v.d_addr; d_wdata_i = v.d_wdata;
    d_funct_i = D_FUNCT;
    #4;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, "m_rvalid", {31'd0, m_rvalid_o}, {31'd0, e.m_v});
      chk(tag, "d_rvalid", {31'd0, d_rvalid_o}, {31'd0, e.d_v});
      chk(tag, "m_rdata", m_rdata_o, e.m_v ? e.data : 32'h0);
      chk(tag, "d_rdata", d_rdata_o, e.d_v ? e.data : 32'h0);
    end
    chk(tag, "m_gnt", {31'd0, m_gnt_o}, {31'd0, v.exp_m_gnt});
    chk(tag, "d_gnt", {31'd0, d_gnt_o}, {31'd0, v.exp_d_gnt});
    chk(tag, "m_stall", {31'd0, m_stall_o}, {31'd0, v.m_req & ~v.exp_m_gnt});
    chk(tag, "gnt_excl", {31'd0, m_gnt_o & d_gnt_o}, 32'd0);
    we = 1'b0; addr = 32'h0; wd = 32'h0; fn = 10'h000;
    if (v.exp_m_gnt) begin
      we = v.m_we; addr = v.m_addr; fn = M_FUNCT; wd = v.m_we ? v.m_wdata : 32'h0;
    end else if (v.exp_d_gnt) begin
      we = v.d_we; addr = v.d_addr; fn = D_FUNCT; wd = v.d_we ? v.d_wdata : 32'h0;
    end
    chk(tag, "ram_r_en", {31'd0, ram_r_en_o}, {31'd0, (v.exp_m_gnt | v.exp_d_gnt) & ~we});
    chk(tag, "ram_w_en", {31'd0, ram_w_en_o}, {31'd0, (v.exp_m_gnt | v.exp_d_gnt) & we});
    chk(tag, "ram_addr", ram_addr_o, addr);
    chk(tag, "ram_funct", {22'd0, ram_funct_o}, {22'd0, fn});
    chk(tag, "ram_wdata", ram_wdata_o, wd);
    n.m_v  = v.exp_m_gnt & ~we;
    n.d_v  = v.exp_d_gnt & ~we;
    n.data = shadow[addr[9:2]];
    exp_q.push_back(n);
    if ((v.exp_m_gnt | v.exp_d_gnt) && we) shadow[addr[9:2]] = wd;
    @(posedge clk_i);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = pat(i);

    // reset, M still requesting: stall follows m_req, nothing granted
    tbl.push_back(mk(1, 1,0,32'h100,0,          1,0,0,32'h3C0,0,          0,0));
    tbl.push_back(mk(1, 1,0,32'h100,0,          0,0,0,0,0,                0,0));
    // single M load
    tbl.push_back(mk(0, 1,0,32'h100,0,          0,0,0,0,0,                1,0));
    tbl.push_back(mk(0, 0,0,0,0,                0,0,0,0,0,                0,0));
    // interleaved M then D reads
    tbl.push_back(mk(0, 1,0,32'h104,0,          0,0,0,0,0,                1,0));
    tbl.push_back(mk(0, 0,0,0,0,                1,0,0,32'h200,0,          0,1));
    tbl.push_back(mk(0, 0,0,0,0,                0,0,0,0,0,                0,0));
    // stores and read-back on both ports
    tbl.push_back(mk(0, 1,1,32'h20,32'hDEADBEEF, 0,0,0,0,0,               1,0));
    tbl.push_back(mk(0, 1,0,32'h20,0,           0,0,0,0,0,                1,0));
    tbl.push_back(mk(0, 0,0,0,0,                1,1,0,32'h40,32'h12345678, 0,1));
    tbl.push_back(mk(0, 0,0,0,0,                1,0,0,32'h40,0,           0,1));
    tbl.push_back(mk(0, 0,0,0,0,                0,0,0,0,0,                0,0));
    // continuous contention: M x4, D once, M x4
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1,0,32'h300 + 32'(4*i),0, 1,0,0,32'h3C0,0,      1,0));
    tbl.push_back(mk(0, 1,0,32'h310,0,          1,0,0,32'h3C0,0,          0,1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 1,0,32'h310 + 32'(4*i),0, 1,0,0,32'h3C4,0,      1,0));
    // starved D wins with lock, holds it, idles locked, then releases to M
    tbl.push_back(mk(0, 1,0,32'h320,0,          1,0,1,32'h3C4,0,          0,1));
    tbl.push_back(mk(0, 1,0,32'h320,0,          1,0,1,32'h3C8,0,          0,1));
    tbl.push_back(mk(0, 1,0,32'h320,0,          1,1,1,32'h3CC,32'hA5A5_5A5A, 0,1));
    tbl.push_back(mk(0, 1,0,32'h320,0,          0,0,1,0,0,                0,0));
    tbl.push_back(mk(0, 1,0,32'h320,0,          1,0,0,32'h3CC,0,          1,0));
    tbl.push_back(mk(0, 0,0,0,0,                0,0,0,0,0,                0,0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

    // hand sequence: reset lands with starve_cnt at 3 and a D read pending
    for (int i = 0; i < 3; i++)
      step(mk(0, 1,0,32'h0C0 + 32'(4*i),0, 1,0,0,32'h0E0,0, 1,0), $sformatf("rs_pre%0d", i));
    step(mk(1, 1,0,32'h0CC,0, 1,0,0,32'h0E0,0, 0,0), "rs_rst");
    // counter was cleared, so M wins the next contention and no stale rvalid appears
    step(mk(0, 1,0,32'h0CC,0, 1,0,0,32'h0E0,0, 1,0), "rs_post");
    step(mk(0, 0,0,0,0, 1,0,0,32'h0E0,0, 0,1), "rs_d");
    step(mk(0, 0,0,0,0, 0,0,0,0,0, 0,0), "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
